// File: rtl/fsk_modulator_if.sv
// Word handshake between a frame source and the FSK modulator.
interface fsk_modulator_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/fsk_modulator.sv
// UART-style framer that steers the mark/space carriers onto the FSK line,
// one symbol per period of the generator's bit clock.
//
// state  | meaning
// IDLE   | line at mark, ready for a word
// ARMED  | word latched, mark held until the next bit tick
// START  | start symbol (0)
// DATA   | data bits, LSB first
// PARITY | even-parity symbol
// STOP   | stop symbol(s) (1)
module fsk_modulator #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_f0,
    input  logic               clk_f1,
    input  logic               clk_serial_bits,
    fsk_modulator_if.slave     tx,
    output logic               tx_busy,
    output logic               line_bit,
    output logic               fsk_out,
    output logic               frame_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, ARMED, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] shift, shift_nx;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
    logic [1:0]        stop_cnt, stop_cnt_nx;
    logic              parity, parity_nx;
    logic              done_nx;

    logic f0_meta, f0_sync, f1_meta, f1_sync;
    logic sb_meta, sb_sync, sb_prev;
    logic run;
    logic bit_tick;
    logic accept;

    // Generator outputs are plain asynchronous data here, never clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f0_meta <= 1'b0;
            f0_sync <= 1'b0;
            f1_meta <= 1'b0;
            f1_sync <= 1'b0;
            sb_meta <= 1'b0;
            sb_sync <= 1'b0;
            sb_prev <= 1'b0;
            run     <= 1'b0;
            fsk_out <= 1'b0;
        end else begin
            f0_meta <= clk_f0;
            f0_sync <= f0_meta;
            f1_meta <= clk_f1;
            f1_sync <= f1_meta;
            sb_meta <= clk_serial_bits;
            sb_sync <= sb_meta;
            sb_prev <= sb_sync;
            run     <= 1'b1;
            fsk_out <= line_bit ? f1_sync : f0_sync;
        end
    end

    assign bit_tick    = sb_sync & ~sb_prev;
    assign tx.tx_ready = run && (state == IDLE) && !frame_done;
    assign accept      = tx.tx_valid && tx.tx_ready;
    assign tx_busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
            parity     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            shift      <= shift_nx;
            bit_cnt    <= bit_cnt_nx;
            stop_cnt   <= stop_cnt_nx;
            parity     <= parity_nx;
            frame_done <= done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        shift_nx    = shift;
        bit_cnt_nx  = bit_cnt;
        stop_cnt_nx = stop_cnt;
        parity_nx   = parity;
        done_nx     = 1'b0;
        line_bit    = 1'b1;
        case (state)
            // A tick in the accept cycle is ignored so START is never short.
            IDLE: begin
                if (accept) begin
                    state_nx  = ARMED;
                    shift_nx  = tx.tx_data;
                    parity_nx = ^tx.tx_data;
                end
            end
            ARMED: begin
                if (bit_tick) state_nx = START;
            end
            START: begin
                line_bit = 1'b0;
                if (bit_tick) begin
                    state_nx   = DATA;
                    bit_cnt_nx = '0;
                end
            end
            DATA: begin
                line_bit = shift[0];
                if (bit_tick) begin
                    shift_nx   = shift >> 1;
                    bit_cnt_nx = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        stop_cnt_nx = '0;
                        state_nx    = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                line_bit = parity;
                if (bit_tick) begin
                    stop_cnt_nx = '0;
                    state_nx    = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        stop_cnt_nx = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fsk_modulator.sv
// Scoreboard bench: channel 0 is an 8N1 modulator, channel 1 an 8E2 one.
module tb_fsk_modulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    logic clk_f0 = 1'b0, clk_f1 = 1'b0, clk_serial_bits = 1'b0;
    logic [1:0] busy, lb, fsk, done, rdy;

    fsk_modulator_if #(.DATA_W(8)) if0 ();
    fsk_modulator_if #(.DATA_W(8)) if1 ();

    fsk_modulator #(.DATA_W(8), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst0), .clk_f0(clk_f0), .clk_f1(clk_f1),
        .clk_serial_bits(clk_serial_bits), .tx(if0),
        .tx_busy(busy[0]), .line_bit(lb[0]), .fsk_out(fsk[0]), .frame_done(done[0]));

    fsk_modulator #(.DATA_W(8), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst1), .clk_f0(clk_f0), .clk_f1(clk_f1),
        .clk_serial_bits(clk_serial_bits), .tx(if1),
        .tx_busy(busy[1]), .line_bit(lb[1]), .fsk_out(fsk[1]), .frame_done(done[1]));

    assign rdy = {if1.tx_ready, if0.tx_ready};

    int total = 0, bad = 0;
    int cyc = 0, since_rst = 0;
    int sb_cnt = 199, f1c = 19, f0c = 99;
    int sym_q0[$], sym_q1[$], len_q0[$], len_q1[$], slen_q0[$], slen_q1[$];
    int exp_done[2], got_done[2], t0[2];
    bit started[2], in_start[2], prev_lb[2], prev_done[2];
    bit b2b_chk = 0;
    int last_done0 = 0;
    logic f1h1 = 0, f1h2 = 0, f1h3 = 0, f0h1 = 0, f0h2 = 0, f0h3 = 0, lbh1 = 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pop_sym(input int ch);
        if (ch == 0) return (sym_q0.size() == 0) ? -1 : sym_q0.pop_front();
        return (sym_q1.size() == 0) ? -1 : sym_q1.pop_front();
    endfunction

    function automatic int pop_len(input int ch);
        if (ch == 0) return (len_q0.size() == 0) ? -1 : len_q0.pop_front();
        return (len_q1.size() == 0) ? -1 : len_q1.pop_front();
    endfunction

    function automatic int pop_slen(input int ch);
        if (ch == 0) return (slen_q0.size() == 0) ? -1 : slen_q0.pop_front();
        return (slen_q1.size() == 0) ? -1 : slen_q1.pop_front();
    endfunction

    function automatic void push_sym(input int ch, input int v);
        if (ch == 0) sym_q0.push_back(v); else sym_q1.push_back(v);
    endfunction

    // Expected symbols: armed mark, start, data LSB first, parity, stops.
    function automatic void push_frame(input int ch, input logic [7:0] d);
        int n;
        int par = (ch == 1) ? 1 : 0;
        int stops = (ch == 1) ? 2 : 1;
        push_sym(ch, 1);
        push_sym(ch, 0);
        for (int i = 0; i < 8; i++) push_sym(ch, int'(d[i]));
        if (par != 0) push_sym(ch, int'(^d));
        for (int i = 0; i < stops; i++) push_sym(ch, 1);
        n = 1;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) break;
            n++;
        end
        if (d == 8'h00 && par != 0) n++;
        if (ch == 0) begin
            len_q0.push_back((1 + 8 + par + stops) * 200);
            slen_q0.push_back(n * 200);
        end else begin
            len_q1.push_back((1 + 8 + par + stops) * 200);
            slen_q1.push_back(n * 200);
        end
        exp_done[ch]++;
    endfunction

    // Raw generator outputs, changed just after each clk edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            sb_cnt = (sb_cnt + 1) % 200;
            f1c = (f1c + 1) % 20;
            f0c = (f0c + 1) % 100;
            clk_serial_bits = (sb_cnt < 100);
            clk_f1 = (f1c < 10);
            clk_f0 = (f0c < 50);
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst0) since_rst++; else since_rst = 0;
        if (since_rst >= 5) chk("fsk_out", int'(fsk[0]), int'(lbh1 ? f1h3 : f0h3));
        f1h3 = f1h2; f1h2 = f1h1; f1h1 = clk_f1;
        f0h3 = f0h2; f0h2 = f0h1; f0h1 = clk_f0;
        lbh1 = lb[0];

        if (b2b_chk && if0.tx_valid && if0.tx_ready) begin
            chk("b2b_gap", cyc - last_done0, 1);
            b2b_chk = 0;
        end

        for (int ch = 0; ch < 2; ch++) begin
            if (sb_cnt == 103 && busy[ch]) chk("symbol", int'(lb[ch]), pop_sym(ch));
            if (done[ch]) begin
                got_done[ch]++;
                if (ch == 0) last_done0 = cyc;
                if (prev_done[ch]) chk("done_width", 2, 1);
                chk("ready_in_done", int'(rdy[ch]), 0);
                if (!started[ch]) chk("done_spurious", 1, 0);
                else chk("frame_len", cyc - t0[ch], pop_len(ch));
                started[ch] = 0;
                in_start[ch] = 0;
            end
            if (in_start[ch] && lb[ch]) begin
                in_start[ch] = 0;
                chk("start_len", cyc - t0[ch], pop_slen(ch));
            end
            if (busy[ch] && prev_lb[ch] && !lb[ch] && !started[ch]) begin
                started[ch] = 1;
                in_start[ch] = 1;
                t0[ch] = cyc;
            end
            if (!busy[ch] && !done[ch]) begin
                started[ch] = 0;
                in_start[ch] = 0;
            end
            prev_lb[ch] = lb[ch];
            prev_done[ch] = done[ch];
        end
    end

    task automatic wait_cnt(input int n);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (sb_cnt == n) return;
        end
        chk("wait_cnt_timeout", 0, 1);
    endtask

    task automatic send(input int ch, input logic [7:0] d, input bit keep);
        bit acc = 0;
        if (ch == 0) begin if0.tx_data = d; if0.tx_valid = 1'b1; end
        else begin if1.tx_data = d; if1.tx_valid = 1'b1; end
        for (int i = 0; i < 6000 && !acc; i++) begin
            acc = rdy[ch];
            @(posedge clk);
            #2;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        if (!keep) begin
            if (ch == 0) if0.tx_valid = 1'b0; else if1.tx_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int ch);
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            if (!busy[ch] && (ch == 0 ? (sym_q0.size() + len_q0.size())
                                      : (sym_q1.size() + len_q1.size())) == 0) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0;
        if0.tx_valid = 1'b0; if0.tx_data = '0;
        if1.tx_valid = 1'b0; if1.tx_data = '0;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_ready", int'(rdy), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_line", int'(lb), 3);
        chk("rst_fsk", int'(fsk), 0);
        chk("rst_done", int'(done), 0);
        #1;
        rst0 = 1'b1; rst1 = 1'b1;
        #1;
        chk("ready_before_edge", int'(rdy), 0);
        @(posedge clk);
        #2;
        chk("ready_after_rst", int'(rdy), 3);

        repeat (300) @(posedge clk);
        #2;
        chk("idle_line", int'(lb), 3);

        wait_cnt(20);
        push_frame(0, 8'hA5);
        send(0, 8'hA5, 0);
        wait_idle(0);

        wait_cnt(20);
        push_frame(1, 8'h07);
        send(1, 8'h07, 0);
        wait_idle(1);

        wait_cnt(20);
        push_frame(0, 8'h3C);
        push_frame(0, 8'hC3);
        send(0, 8'h3C, 1);
        b2b_chk = 1;
        send(0, 8'hC3, 0);
        wait_idle(0);

        // Valid raised in the tick cycle: accept and tick share one edge.
        wait_cnt(2);
        push_frame(0, 8'h01);
        send(0, 8'h01, 0);
        wait_idle(0);

        wait_cnt(20);
        push_sym(0, 1); push_sym(0, 0);
        for (int i = 0; i < 4; i++) push_sym(0, 1);
        slen_q0.push_back(200);
        send(0, 8'hFF, 0);
        for (int i = 0; i < 2000 && sym_q0.size() != 0; i++) @(posedge clk);
        chk("pre_reset_syms", sym_q0.size(), 0);
        wait_cnt(150);
        #1;
        rst0 = 1'b0;
        #1;
        chk("midrst_line", int'(lb[0]), 1);
        chk("midrst_busy", int'(busy[0]), 0);
        chk("midrst_ready", int'(rdy[0]), 0);
        chk("midrst_done", int'(done[0]), 0);
        repeat (3) @(posedge clk);
        #3;
        rst0 = 1'b1;
        repeat (10) @(posedge clk);

        wait_cnt(20);
        push_frame(0, 8'h5A);
        send(0, 8'h5A, 0);
        wait_idle(0);

        repeat (20) @(posedge clk);
        #2;
        chk("done_count0", got_done[0], exp_done[0]);
        chk("done_count1", got_done[1], exp_done[1]);
        chk("left_sym", sym_q0.size() + sym_q1.size(), 0);
        chk("left_len", len_q0.size() + len_q1.size() + slen_q0.size() + slen_q1.size(), 0);
        chk("b2b_seen", int'(b2b_chk), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
